// File: rtl/box_downscaler_2x.sv
// rtl/box_downscaler_2x.sv - streaming 2x2 box-average decimator for RGB444 raster pixels
//
// Purpose: averages every 2x2 source block per channel (round half up) and
// emits one pixel with its half-resolution write coordinates.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   in_valid, in_sof    source pixel strobe; sof marks source (0,0)
//   in_data[11:0]       source pixel {R,G,B} nibbles
//   out_valid           one-cycle strobe for out_data/out_x/out_y
//   out_data[11:0]      averaged pixel
//   out_x[XW-1:0]       destination column
//   out_y[YW-1:0]       destination row
//   frame_done          one-cycle strobe with the last block of a frame
module box_downscaler_2x #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int XW         = $clog2(SRC_WIDTH / 2),
  parameter int YW         = $clog2(SRC_HEIGHT / 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [11:0]   in_data,
  output logic          out_valid,
  output logic [11:0]   out_data,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done
);

  // Source counters are one bit wider than the destination coordinates,
  // so the upper bits of a source coordinate are the destination coordinate.
  localparam int SXW = XW + 1;
  localparam int SYW = YW + 1;

  logic [SXW-1:0] sx_q, sx_d, cur_x;
  logic [SYW-1:0] sy_q, sy_d, cur_y;
  logic           last_x, last_y;
  logic [11:0]    hold_q;
  logic [14:0]    line_buf [SRC_WIDTH/2];
  logic [14:0]    rd_q;
  logic [14:0]    cur_pair;
  logic [11:0]    avg;
  logic           emit;
  logic [XW-1:0]  blk_x;

  logic          out_valid_q, frame_done_q;
  logic [11:0]   out_data_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  function automatic logic [14:0] pair_sum(input logic [11:0] a, input logic [11:0] b);
    pair_sum = {{1'b0, a[11:8]} + {1'b0, b[11:8]},
                {1'b0, a[7:4]}  + {1'b0, b[7:4]},
                {1'b0, a[3:0]}  + {1'b0, b[3:0]}};
  endfunction

  function automatic logic [3:0] round4(input logic [4:0] p, input logic [4:0] q);
    logic [5:0] s;
    s = {1'b0, p} + {1'b0, q} + 6'd2;
    round4 = s[5:2];
  endfunction

  // A pixel flagged sof is position (0,0) whatever the counters say.
  always_comb begin
    cur_x  = in_sof ? '0 : sx_q;
    cur_y  = in_sof ? '0 : sy_q;
    last_x = (cur_x == SXW'(SRC_WIDTH - 1));
    last_y = (cur_y == SYW'(SRC_HEIGHT - 1));
    sx_d   = last_x ? '0 : cur_x + 1'b1;
    sy_d   = cur_y;
    if (last_x) sy_d = last_y ? '0 : cur_y + 1'b1;
    blk_x    = cur_x[SXW-1:1];
    cur_pair = pair_sum(hold_q, in_data);
    avg      = {round4(cur_pair[14:10], rd_q[14:10]),
                round4(cur_pair[9:5],   rd_q[9:5]),
                round4(cur_pair[4:0],   rd_q[4:0])};
    emit     = in_valid && cur_x[0] && cur_y[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q         <= '0;
      sy_q         <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= emit && last_x && last_y;
      if (in_valid) begin
        sx_q <= sx_d;
        sy_q <= sy_d;
        if (!cur_x[0]) hold_q <= in_data;
      end
      if (emit) begin
        out_data_q <= avg;
        out_x_q    <= blk_x;
        out_y_q    <= cur_y[SYW-1:1];
      end
    end
  end

  // Line buffer holds top-row pair sums; it needs no reset because every
  // entry is rewritten by the even row before the odd row reads it. The read
  // is launched by the even pixel of an odd-row pair and rd_q keeps it across
  // any idle gap before the odd pixel.
  always_ff @(posedge clk) begin
    if (in_valid && cur_x[0] && !cur_y[0]) line_buf[blk_x] <= cur_pair;
    if (in_valid && !cur_x[0] && cur_y[0]) rd_q <= line_buf[blk_x];
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_data   = out_data_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;

endmodule

// File: tb/tb_box_downscaler_2x.sv
// tb/tb_box_downscaler_2x.sv - scoreboard bench for box_downscaler_2x
module tb_box_downscaler_2x;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [11:0]   in_data = '0;
  logic          out_valid;
  logic [11:0]   out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          frame_done;

  box_downscaler_2x #(.SRC_WIDTH(W), .SRC_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int          x;
    int          y;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_done = 0;
  int   seen_done = 0;

  // reference model state
  int          msx = 0, msy = 0;
  logic [11:0] row0 [W];
  logic [11:0] mhold = '0;
  logic        ovr_en = 1'b0;
  logic [11:0] ovr_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("frame_done_without_valid", int'(frame_done && !out_valid), 0);
      if (frame_done) seen_done++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("frame_done", frame_done, e.done);
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [3:0] avg4(input logic [3:0] a, b, c, d);
    int s;
    s = a + b + c + d + 2;
    return 4'(s / 4);
  endfunction

  // drive one pixel; called at a negedge
  task automatic pix(input logic [11:0] d, input logic sof);
    exp_t e;
    if (sof) begin msx = 0; msy = 0; end
    if (msy % 2 == 0) row0[msx] = d;
    if (msx % 2 == 0) mhold = d;
    else if (msy % 2 == 1) begin
      e.d = {avg4(row0[msx-1][11:8], row0[msx][11:8], mhold[11:8], d[11:8]),
             avg4(row0[msx-1][7:4],  row0[msx][7:4],  mhold[7:4],  d[7:4]),
             avg4(row0[msx-1][3:0],  row0[msx][3:0],  mhold[3:0],  d[3:0])};
      if (ovr_en) e.d = ovr_d;
      e.x    = msx / 2;
      e.y    = msy / 2;
      e.done = (msx == W - 1) && (msy == H - 1);
      e.cyc  = cyc + 1;
      if (e.done) exp_done++;
      exp_q.push_back(e);
    end
    msx++;
    if (msx == W) begin
      msx = 0;
      msy = (msy + 1) % H;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 12'($urandom);
  endtask

  // idle cycles with junk on data/sof to prove they are ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_data  = 12'($urandom);
      @(negedge clk);
    end
    in_sof = 1'b0;
  endtask

  function automatic logic [11:0] grad(input int x, input int y);
    logic [3:0] r, g, b;
    r = 4'(x);
    g = 4'(y);
    b = 4'(x ^ y);
    return {r, g, b};
  endfunction

  task automatic pattern_frame(input logic [11:0] tl, tr, bl, br, exp_d);
    ovr_en = 1'b1;
    ovr_d  = exp_d;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix((y % 2 == 0) ? ((x % 2 == 0) ? tl : tr) : ((x % 2 == 0) ? bl : br),
            (x == 0 && y == 0));
    ovr_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // constant frame
    pattern_frame(12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C);
    idle(3);

    // rounding cases
    pattern_frame(12'h000, 12'h001, 12'h001, 12'h001, 12'h001);
    pattern_frame(12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
    pattern_frame(12'h000, 12'h000, 12'h001, 12'h001, 12'h001);
    pattern_frame(12'h000, 12'h000, 12'h000, 12'h001, 12'h000);
    idle(2);

    // saturated pixels with random gaps, including inside pairs
    ovr_en = 1'b1;
    ovr_d  = 12'hFFF;
    for (int i = 0; i < W * H; i++) begin
      idle($urandom_range(0, 5));
      pix(12'hFFF, i == 0);
    end
    ovr_en = 1'b0;
    idle(2);

    // gradient, three back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          pix(grad(x + f, y + f), f == 0 && x == 0 && y == 0);
    idle(2);

    // sof at source (5,1): abandon the partial frame
    for (int i = 0; i < W + 5; i++) pix(grad(i % W, i / W), i == 0);
    for (int i = 0; i < W * H; i++) pix(grad(7 - i % W, i / W), i == 0);
    idle(2);

    // reset at source (3,3)
    for (int i = 0; i < 3 * W + 3; i++) pix(grad(i % W, (i / W) + 2), i == 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_x", out_x, 0);
    check("midrst_out_y", out_y, 0);
    check("midrst_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    msx = 0;
    msy = 0;
    mhold = '0;
    for (int i = 0; i < W * H; i++) pix(grad(i % W + 3, i / W), 1'b0);
    idle(4);

    check("scoreboard_empty", exp_q.size(), 0);
    check("frame_done_count", seen_done, exp_done);
    check("frame_done_total", exp_done, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/box_downscaler_2x.md
# box_downscaler_2x

Streaming 2:1 decimator in both axes for 12-bit RGB444 pixels. It is the capture-side counterpart of the bilinear upscaler. Raster pixels from the camera path arrive at source resolution. Each 2x2 block is averaged per channel into one output pixel, with write coordinates for the half-resolution frame buffer. The display path then upscales those pixels back to full size.

## Interface
- SRC_WIDTH, 640, source pixels per line; must be even, ≥ 4.
- SRC_HEIGHT, 480, source lines per frame; must be even, ≥ 2.
- XW, $clog2(SRC_WIDTH/2), output x coordinate width (derived).
- YW, $clog2(SRC_HEIGHT/2), output y coordinate width (derived).
- clk  input  1  pixel clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a source pixel this cycle.
- in_sof  input  1  qualified by in_valid; this pixel is source (0,0).
- in_data  input  12  source pixel {R[11:8], G[7:4], B[3:0]}.
- out_valid  output  1  one-cycle strobe; out_data/out_x/out_y valid.
- out_data  output  12  averaged pixel, same packing as in_data.
- out_x  output  XW  destination column, 0..SRC_WIDTH/2-1.
- out_y  output  YW  destination row, 0..SRC_HEIGHT/2-1.
- frame_done  output  1  one-cycle strobe coincident with the out_valid of the last block of a frame.

## Operation
- Internal source counters: sx (0..SRC_WIDTH-1) and sy (0..SRC_HEIGHT-1). Both advance only on in_valid.
  - sx wraps to 0 after SRC_WIDTH-1 and increments sy.
  - sy wraps to 0 after SRC_HEIGHT-1.
- in_sof with in_valid: that pixel is treated as sx=0, sy=0 regardless of counter state. Any partially accumulated block is discarded, and counters resume from (1,0) for the next pixel. in_sof without in_valid is ignored.
- Per-channel arithmetic is unsigned.
  - Pair sums are 5 bits per channel (15 bits per pair).
  - Block sums are 6 bits per channel.
  - Output is (block_sum + 2) >> 2, i.e. round half up. The maximum is (60+2)>>2 = 15, so it never overflows.
- Even sx: latch in_data in a holding register.
- Odd sx, even sy: write the pair sum (held + current) into line buffer entry sx>>1. The buffer has SRC_WIDTH/2 entries of 15 bits.
- Odd sx, odd sy:
  - Form the current pair sum and add line buffer entry sx>>1.
  - Round, then register the result onto out_data.
  - out_x = sx>>1, out_y = sy>>1; assert out_valid.
- The line buffer may be a synchronous-read RAM. The read is issued on the even-sx pixel of each odd-row pair, and the data is held until the odd pixel arrives, however many idle cycles intervene.
- There is no backpressure: every accepted pixel is consumed. The downstream frame-buffer writer must accept every out_valid strobe.
- frame_done is asserted with out_valid when sx=SRC_WIDTH-1 and sy=SRC_HEIGHT-1.

## Timing
- Reset (async assert, sync deassert at the system level):
  - sx=0, sy=0, holding register 0.
  - out_valid=0, out_data=12'h000, out_x=0, out_y=0, frame_done=0.
  - Line buffer contents are not reset. They are overwritten by the next even row before use.
- Latency: out_valid rises exactly 1 clk after the accepting edge of the bottom-right pixel of a block.
- out_valid and frame_done last exactly one cycle. The output data/coordinates hold their last values until the next strobe.
- Peak rate: one output per 2 accepted pixels on odd rows; zero outputs on even rows.
- Idle gaps in in_valid of any length, at any position (including between the two pixels of a pair), must not change results.
- Reset mid-frame:
  - outputs clear immediately;
  - the next pixel is treated as (0,0) even without in_sof;
  - no stale block may be emitted.
- in_sof on the pixel right after an odd-row even-sx pixel: no output for the abandoned block.

## Test plan
- SRC_WIDTH=8, SRC_HEIGHT=4, all pixels 12'hA5C -> 8 strobes, each out_data=12'hA5C. Coordinates run (0,0)..(3,1) in raster order, and frame_done is asserted only with (3,1).
- One block with TL=12'h000, TR=12'h001, BL=12'h001, BR=12'h001 -> out_data=12'h001. With all four 12'h001 -> 12'h001. With TL=TR=12'h000, BL=BR=12'h001 -> 12'h001 (2+2>>2, round up). With all 12'h000 except BR=12'h001 -> 12'h000.
- All pixels 12'hFFF with random 0-5 cycle in_valid gaps, including inside pairs -> every out_data=12'hFFF. Each strobe is 1 cycle after its BR pixel; the count is 8 per frame.
- Gradient frame (R=sx, G=sy, B=sx^sy) over 3 back-to-back frames -> out_data matches a rounded 2x2-average model. frame_done fires 3 times, once per frame.
- in_sof asserted at source (5,1) mid-frame -> no strobe for the partial block. The next outputs restart at (0,0), and a full frame follows.
- rst_n pulsed low at source (3,3) -> outputs read 0 during reset. The following 32 pixels without in_sof produce a correct full frame starting at (0,0).
